// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction prefetch queue sitting between instruction memory
// and decode. Requests are issued against a credit of DEPTH slots (queued
// entries plus the outstanding request). A redirect from execute flushes the
// queue, drops the response in flight and restarts fetch at the target.
// Optional build macro: INSTR_PREFETCH_PERF_EN adds perf_fetched,
// perf_redirects and perf_empty counter outputs.
module instr_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_src_exec,
  input  logic [XLEN-1:0] pc_target_exec,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_next_pc
`ifdef INSTR_PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_empty
`endif
);

  // Pointer width and occupancy width (occupancy must hold DEPTH itself).
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    FETCH      = 1'b0,
    WAIT_SPACE = 1'b1
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] req_addr_reg;
  logic            inflight_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;

  // Queue storage: one word per field, written only on a committed push.
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] npc_mem   [DEPTH];

  logic redirect;
  logic issue;
  logic push;
  logic pop;

  // Redirect dominates everything: it suppresses the request, drops the
  // arriving response and turns any handshake into a plain consume.
  assign redirect  = pc_src_exec;
  assign issue     = reset && (state_reg == FETCH) && !redirect;
  assign push      = inflight_reg && !redirect;
  assign pop       = dec_valid && dec_ready && !redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_reg;

  // Head entry is presented only while valid so that stale storage never
  // leaks out (storage is not reset, the qualifier is).
  assign dec_valid   = (count_reg != '0);
  assign dec_instr   = dec_valid ? instr_mem[rd_ptr_reg] : '0;
  assign dec_pc      = dec_valid ? pc_mem[rd_ptr_reg]    : '0;
  assign dec_next_pc = dec_valid ? npc_mem[rd_ptr_reg]   : '0;

  // Next occupancy and FSM state; WAIT_SPACE means every credit is in use.
  always_comb begin
    count_next = count_reg;
    state_next = FETCH;
    if (redirect) begin
      count_next = '0;
      state_next = FETCH;
    end else begin
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CW'(1);
      end
      if ((count_next + CW'(issue)) == CW'(DEPTH)) begin
        state_next = WAIT_SPACE;
      end else begin
        state_next = FETCH;
      end
    end
  end

  // Control state: fetch PC, outstanding request, pointers, occupancy, FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      inflight_reg <= issue;
      if (issue) begin
        req_addr_reg <= fetch_pc_reg;
      end
      if (redirect) begin
        fetch_pc_reg <= pc_target_exec;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
      end else begin
        if (issue) begin
          fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
      end
    end
  end

  // Per-entry storage write, selected by the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the returning instruction with the address that fetched it.
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi))) begin
          instr_mem[gi] <= imem_rdata;
          pc_mem[gi]    <= req_addr_reg;
          npc_mem[gi]   <= req_addr_reg + XLEN'(4);
        end
      end
    end
  endgenerate

  // The credit rule must make a push into a full queue impossible.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!reset) !(push && (count_reg == CW'(DEPTH)))
  );

`ifdef INSTR_PREFETCH_PERF_EN
  // Free-running, wrapping event counters for performance analysis.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
      perf_empty     <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
      if (!dec_valid) begin
        perf_empty <= perf_empty + 32'd1;
      end
    end
  end
`endif

endmodule
